updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised up/down modulo counter with a built-in prescaler.
//  Features: programmable terminal value, parallel load, wrap or saturate mode,
//  a one-cycle terminal-count pulse and a sticky overflow flag.
//  Successor to the plain up-counter for timers, baud/tick generators and event
//  counting; sits beside the FFD/counter collaterals and is driven by one clock.
// PARAMETERS
//  SIZE      16  counter width in bits
//  PRESCALE   1  enabled cycles per count step (1..2^16); 1 = step on every enabled cycle
// PORTS
//  Clock          in   1     system clock, all state updates on posedge
//  Reset          in   1     asynchronous, active-high; clears all state
//  Enable         in   1     prescaler/count enable
//  Load           in   1     synchronous parallel load
//  LoadValue      in   SIZE  value applied on Load
//  Limit          in   SIZE  terminal value; count range is 0..Limit
//  Up             in   1     1 = count up, 0 = count down
//  Saturate       in   1     1 = hold at the boundary, 0 = wrap
//  ClearOverflow  in   1     synchronous clear of Overflow
//  Q              out  SIZE  current count (registered)
//  TerminalCount  out  1     one-cycle pulse on a boundary step (registered)
//  Overflow       out  1     sticky; set on any boundary step
// BEHAVIOUR
//  - Reset (async): Q=0, prescaler=0, TerminalCount=0, Overflow=0. The clear is immediate;
//    operation resumes on the first posedge after deassertion.
//  - Priority per edge: Reset > Load > step > hold.
//  - Load: Q <= (LoadValue > Limit) ? Limit : LoadValue. The prescaler clears to 0.
//    TerminalCount=0 that cycle. Enable is ignored that cycle.
//  - Prescaler: internal count 0..PRESCALE-1. It advances only when Enable=1 and Load=0.
//    A step fires when Enable=1 and prescaler==PRESCALE-1, and the prescaler then wraps to 0.
//    With PRESCALE=1 a step fires on every enabled cycle.
//    Enable=0 freezes both the prescaler and Q.
//  - Step, Up=1:
//    - Q < Limit: Q+1.
//    - Q >= Limit (boundary): Q <= Saturate ? Limit : 0.
//  - Step, Up=0:
//    - Q > Limit: Q <= Limit. This is not a boundary.
//    - 0 < Q <= Limit: Q-1.
//    - Q == 0 (boundary): Q <= Saturate ? 0 : Limit.
//  - Boundary step: TerminalCount=1 for exactly the cycle in which Q shows the post-step value.
//    It is also 1 when saturating, even though Q does not change. Otherwise TerminalCount=0.
//  - Overflow: set on a boundary step, cleared by ClearOverflow.
//    If both happen in the same cycle, set wins.
//  - Limit=0: Q stays 0 and every step is a boundary, so TerminalCount pulses at the step rate.
//  - Up, Saturate and Limit are sampled on each edge. Changing them mid-count takes effect on
//    the next step; there is no pipeline.
//  - Latency: Load/step to Q is 1 cycle; TerminalCount is coincident with Q.
//  - Width: all arithmetic is modulo 2^SIZE, and Limit=2^SIZE-1 gives a full-range counter.
// TESTING
//  1 Reset mid-count: SIZE=8, Q=0x37, assert Reset between edges -> Q=0, TC=0, OVF=0 immediately.
//  2 Up wrap: Limit=5, Up=1, Saturate=0, Enable=1, PRESCALE=1 -> Q 0,1,2,3,4,5,0;
//    TC=1 only in the cycle Q returns to 0; OVF=1 thereafter.
//  3 Down saturate: Limit=5, load 2, Up=0, Saturate=1 -> Q 2,1,0,0,0; TC pulses on each step at 0.
//  4 Prescale: PRESCALE=3, Enable=1 -> Q increments every 3rd cycle;
//    Enable low for 2 cycles mid-period delays the next step by exactly 2 cycles.
//  5 Load clamp/priority: Limit=10, LoadValue=20, Load=1 with Enable=1 and a step due
//    -> Q=10, TC=0, prescaler=0.
//  6 Overflow set vs clear: ClearOverflow=1 in the same cycle as a boundary step -> OVF stays 1;
//    ClearOverflow alone next cycle -> OVF=0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//
// Up/down modulo counter with a built-in prescaler, programmable terminal
// value, parallel load, wrap or saturate behaviour, a one-cycle terminal-count
// pulse and a sticky overflow flag. It is intended for timers, baud/tick
// generators and event counting.
//
// Parameters
//   SIZE      counter width in bits
//   PRESCALE  enabled cycles per count step (1..2^16); 1 = step on every
//             enabled cycle
//
// Ports
//   clk_i             system clock; all state updates on the rising edge
//   rst_i             asynchronous, active-high; clears all state at once
//   enable_i          prescaler/count enable
//   load_i            synchronous parallel load (beats any step)
//   load_value_i      value applied on load, clamped to limit_i
//   limit_i           terminal value; the count range is 0..limit_i
//   up_i              1 = count up, 0 = count down
//   saturate_i        1 = hold at the boundary, 0 = wrap around
//   clear_overflow_i  synchronous clear of overflow_o
//   q_o               current count (registered)
//   terminal_count_o  one-cycle pulse that coincides with the post-step value
//                     of a boundary step (registered)
//   overflow_o        sticky flag, set on any boundary step
// -----------------------------------------------------------------------------
module updown_mod_counter #(
  parameter int SIZE     = 16,
  parameter int PRESCALE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            load_i,
  input  logic [SIZE-1:0] load_value_i,
  input  logic [SIZE-1:0] limit_i,
  input  logic            up_i,
  input  logic            saturate_i,
  input  logic            clear_overflow_i,
  output logic [SIZE-1:0] q_o,
  output logic            terminal_count_o,
  output logic            overflow_o
);

  // Width of the prescaler count; a single bit is kept even when PRESCALE=1
  // so the declaration stays legal, although no register is built then.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic            step_fire;
  logic            boundary;
  logic [SIZE-1:0] q_q, q_d;
  logic            tc_q, tc_d;
  logic            ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Prescaler: counts enabled, non-load cycles 0..PRESCALE-1. A step fires on
  // the cycle the prescaler sits at its last value. Load restarts the period.
  // ---------------------------------------------------------------------------
  generate
    if (PRESCALE > 1) begin : g_prescaler
      localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

      logic [PS_W-1:0] ps_q, ps_d;

      always_comb begin
        ps_d = ps_q;
        if (load_i) begin
          ps_d = '0;
        end else if (enable_i) begin
          ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          ps_q <= '0;
        end else begin
          ps_q <= ps_d;
        end
      end

      assign step_fire = enable_i && !load_i && (ps_q == PS_LAST);
    end else begin : g_no_prescaler
      assign step_fire = enable_i && !load_i;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic for the count, terminal-count pulse and overflow flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_d      = q_q;
    boundary = 1'b0;

    if (load_i) begin
      // Out-of-range load values are clamped to the terminal value.
      q_d = (load_value_i > limit_i) ? limit_i : load_value_i;
    end else if (step_fire) begin
      if (up_i) begin
        if (q_q < limit_i) begin
          // Cannot overflow SIZE bits because q_q is strictly below limit_i.
          q_d = q_q + SIZE'(1);
        end else begin
          boundary = 1'b1;
          q_d      = saturate_i ? limit_i : '0;
        end
      end else begin
        if (q_q > limit_i) begin
          // A count left above a lowered limit is pulled back into range;
          // this is a normal step, not a boundary.
          q_d = limit_i;
        end else if (q_q != '0) begin
          q_d = q_q - SIZE'(1);
        end else begin
          boundary = 1'b1;
          q_d      = saturate_i ? '0 : limit_i;
        end
      end
    end

    // Pulse is registered so it lines up with the post-step count.
    tc_d = boundary;

    // Setting beats clearing when both land on the same edge.
    if (boundary) begin
      ovf_d = 1'b1;
    end else if (clear_overflow_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q_o              = q_q;
  assign terminal_count_o = tc_q;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_mod_counter
//
// Two instances (PRESCALE=1 and PRESCALE=3, SIZE=8) share one set of inputs.
// A behavioural model written from the counting rules tracks each instance,
// and every scenario task compares both instances against it (plus a few
// hand-written expected sequences) one cycle at a time.
// -----------------------------------------------------------------------------
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, ld, up, sat, clr;
  logic [7:0] lv, lim;

  logic [7:0] q1, q3;
  logic       tc1, tc3, ov1, ov3;
  logic [9:0] v1, v3;

  assign v1 = {q1, tc1, ov1};
  assign v3 = {q3, tc3, ov3};

  always #5 clk = ~clk;

  updown_mod_counter #(.SIZE(8), .PRESCALE(1)) dut_p1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .load_i(ld),
    .load_value_i(lv), .limit_i(lim), .up_i(up), .saturate_i(sat),
    .clear_overflow_i(clr), .q_o(q1), .terminal_count_o(tc1), .overflow_o(ov1)
  );

  updown_mod_counter #(.SIZE(8), .PRESCALE(3)) dut_p3 (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .load_i(ld),
    .load_value_i(lv), .limit_i(lim), .up_i(up), .saturate_i(sat),
    .clear_overflow_i(clr), .q_o(q3), .terminal_count_o(tc3), .overflow_o(ov3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 3.
  int presc[2] = '{1, 3};
  int m_q[2];
  int m_ps[2];
  bit m_tc[2];
  bit m_ov[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 0; m_ps[i] = 0; m_tc[i] = 0; m_ov[i] = 0;
    end
  endfunction

  // One rising edge of the reference, using the inputs currently applied.
  function automatic void model_clock();
    for (int i = 0; i < 2; i++) begin
      bit stepnow = 0;
      bit bnd     = 0;
      int l       = int'(lim);
      if (ld) begin
        m_q[i]  = (int'(lv) > l) ? l : int'(lv);
        m_ps[i] = 0;
      end else if (en) begin
        if (m_ps[i] == presc[i] - 1) begin
          stepnow = 1;
          m_ps[i] = 0;
        end else begin
          m_ps[i] = m_ps[i] + 1;
        end
      end
      if (stepnow) begin
        if (up) begin
          if (m_q[i] < l) m_q[i] = m_q[i] + 1;
          else begin bnd = 1; m_q[i] = sat ? l : 0; end
        end else begin
          if (m_q[i] > l) m_q[i] = l;
          else if (m_q[i] > 0) m_q[i] = m_q[i] - 1;
          else begin bnd = 1; m_q[i] = sat ? 0 : l; end
        end
      end
      m_tc[i] = bnd;
      if (bnd) m_ov[i] = 1;
      else if (clr) m_ov[i] = 0;
    end
  endfunction

  function automatic logic [9:0] exp_vec(int i);
    return {8'(m_q[i]), m_tc[i], m_ov[i]};
  endfunction

  // Advance one clock; leaves time 1 unit after the edge for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; ld = 0; up = 1; sat = 0; clr = 0; lv = 8'h00; lim = 8'hFF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [9:0] got;
    idle_inputs();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (v1 !== 10'd0 || v3 !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got p1=%h p3=%h, required 000 000", v1, v3);
    end
    rst = 1'b0;
    // Bring the count to 0x37 and run a little, then reset between edges.
    ld = 1; lv = 8'h37;
    cyc();
    n_checks++;
    if (q1 !== 8'h37) begin
      n_fail++;
      $display("FAIL reset_load37: got q=%h, required 37", q1);
    end
    ld = 0; en = 1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? v1 : v3;
        n_checks++;
        if (got !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL reset_precount P=%0d cyc=%0d: got q=%0d tc=%b ovf=%b, required q=%0d tc=%b ovf=%b",
                   presc[i], k, got[9:2], got[1], got[0], m_q[i], m_tc[i], m_ov[i]);
        end
      end
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (v1 !== 10'd0 || v3 !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_async_midcount: got p1=%h p3=%h, required 000 000", v1, v3);
    end
    rst = 1'b0;
    en = 0;
    $display("test_reset done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_up_wrap();
    int         exp_q[7] = '{1, 2, 3, 4, 5, 0, 1};
    logic [9:0] got;
    idle_inputs();
    do_reset();
    lim = 8'd5; up = 1; sat = 0; en = 1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      n_checks++;
      if (q1 !== 8'(exp_q[k]) || tc1 !== (k == 5) || ov1 !== (k >= 5)) begin
        n_fail++;
        $display("FAIL up_wrap_seq cyc=%0d: got q=%0d tc=%b ovf=%b, required q=%0d tc=%b ovf=%b",
                 k, q1, tc1, ov1, exp_q[k], (k == 5), (k >= 5));
      end
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? v1 : v3;
        n_checks++;
        if (got !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL up_wrap P=%0d cyc=%0d: got q=%0d tc=%b ovf=%b, required q=%0d tc=%b ovf=%b",
                   presc[i], k, got[9:2], got[1], got[0], m_q[i], m_tc[i], m_ov[i]);
        end
      end
    end
    $display("test_up_wrap done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_down_saturate();
    int         exp_q[5]  = '{2, 1, 0, 0, 0};
    bit         exp_tc[5] = '{0, 0, 0, 1, 1};
    logic [9:0] got;
    idle_inputs();
    do_reset();
    lim = 8'd5; lv = 8'd2; ld = 1; up = 0; sat = 1; en = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      ld = 0;
      n_checks++;
      if (q1 !== 8'(exp_q[k]) || tc1 !== exp_tc[k]) begin
        n_fail++;
        $display("FAIL down_sat_seq cyc=%0d: got q=%0d tc=%b, required q=%0d tc=%b",
                 k, q1, tc1, exp_q[k], exp_tc[k]);
      end
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? v1 : v3;
        n_checks++;
        if (got !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL down_sat P=%0d cyc=%0d: got q=%0d tc=%b ovf=%b, required q=%0d tc=%b ovf=%b",
                   presc[i], k, got[9:2], got[1], got[0], m_q[i], m_tc[i], m_ov[i]);
        end
      end
    end
    $display("test_down_saturate done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_prescale();
    // Enable pattern: 7 on, 2 off mid-period, 6 on.
    bit         en_pat[15] = '{1,1,1,1,1,1,1,0,0,1,1,1,1,1,1};
    logic [9:0] got;
    idle_inputs();
    do_reset();
    lim = 8'd255; up = 1;
    for (int k = 0; k < 15; k++) begin
      en = en_pat[k];
      cyc();
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? v1 : v3;
        n_checks++;
        if (got !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL prescale P=%0d cyc=%0d: got q=%0d tc=%b ovf=%b, required q=%0d tc=%b ovf=%b",
                   presc[i], k, got[9:2], got[1], got[0], m_q[i], m_tc[i], m_ov[i]);
        end
      end
    end
    // 13 enabled cycles at PRESCALE 3 means exactly four steps.
    n_checks++;
    if (q3 !== 8'd4) begin
      n_fail++;
      $display("FAIL prescale_total: got q=%0d, required q=4", q3);
    end
    $display("test_prescale done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_clamp();
    logic [9:0] got;
    idle_inputs();
    do_reset();
    lim = 8'd10; up = 1; en = 1;
    cyc();
    cyc();                       // PRESCALE 3 instance now has a step due
    ld = 1; lv = 8'd20;
    cyc();
    ld = 0;
    n_checks++;
    if (q3 !== 8'd10 || tc3 !== 1'b0 || q1 !== 8'd10 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp: got q1=%0d tc1=%b q3=%0d tc3=%b, required q=10 tc=0",
               q1, tc1, q3, tc3);
    end
    // Prescaler was cleared: the next P3 step comes after three enabled cycles.
    for (int k = 0; k < 4; k++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? v1 : v3;
        n_checks++;
        if (got !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL load_after P=%0d cyc=%0d: got q=%0d tc=%b ovf=%b, required q=%0d tc=%b ovf=%b",
                   presc[i], k, got[9:2], got[1], got[0], m_q[i], m_tc[i], m_ov[i]);
        end
      end
    end
    $display("test_load_clamp done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overflow_clear();
    idle_inputs();
    do_reset();
    lim = 8'd3; lv = 8'd3; ld = 1;
    cyc();
    ld = 0; en = 1; clr = 1;     // boundary step and clear on the same edge
    cyc();
    n_checks++;
    if (ov1 !== 1'b1 || tc1 !== 1'b1 || q1 !== 8'd0) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got q=%0d tc=%b ovf=%b, required q=0 tc=1 ovf=1", q1, tc1, ov1);
    end
    en = 0; clr = 1;
    cyc();
    n_checks++;
    if (ov1 !== 1'b0 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got tc=%b ovf=%b, required tc=0 ovf=0", tc1, ov1);
    end
    n_checks++;
    if (v3 !== exp_vec(1)) begin
      n_fail++;
      $display("FAIL ovf_clear_p3: got %h, required %h", v3, exp_vec(1));
    end
    $display("test_overflow_clear done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_limit_zero();
    logic [9:0] got;
    idle_inputs();
    do_reset();
    lim = 8'd0; en = 1;
    for (int k = 0; k < 7; k++) begin
      up  = k[0];
      sat = k[1];
      cyc();
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? v1 : v3;
        n_checks++;
        if (got !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL limit_zero P=%0d cyc=%0d: got q=%0d tc=%b ovf=%b, required q=%0d tc=%b ovf=%b",
                   presc[i], k, got[9:2], got[1], got[0], m_q[i], m_tc[i], m_ov[i]);
        end
      end
    end
    $display("test_limit_zero done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [9:0] got;
    idle_inputs();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      en  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 15) == 0);
      lv  = 8'($urandom);
      up  = ($urandom_range(0, 3) != 0);
      sat = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 15))
        0:       lim = 8'd0;
        1:       lim = 8'd255;
        2, 3:    lim = 8'($urandom);
        default: lim = lim;
      endcase
      if (k == 0) lim = 8'd7;
      cyc();
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? v1 : v3;
        n_checks++;
        if (got !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL random P=%0d cyc=%0d: got q=%0d tc=%b ovf=%b, required q=%0d tc=%b ovf=%b",
                   presc[i], k, got[9:2], got[1], got[0], m_q[i], m_tc[i], m_ov[i]);
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_saturate();
    test_prescale();
    test_load_clamp();
    test_overflow_clear();
    test_limit_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
